fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of instruction-buffer entries (power of two, minimum 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the fetch-stall counter.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port imemaddr  in  32  current PC from program_counter.
REQ-006 SHALL have port pc_en  out  1  advance/redirect enable to program_counter.
REQ-007 SHALL have port imemREN  out  1  instruction-cache read request.
REQ-008 SHALL have port icache_addr  out  32  instruction-cache address; equals imemaddr.
REQ-009 SHALL have port ihit  in  1  cache returns imemload this cycle.
REQ-010 SHALL have port imemload  in  32  instruction word from the cache.
REQ-011 SHALL have port flush  in  1  taken branch/jump/JR redirect from decode.
REQ-012 SHALL have port halt  in  1  halt detected downstream.
REQ-013 SHALL have port dec_valid  out  1  head entry valid.
REQ-014 SHALL have port dec_ready  in  1  decode accepts head entry.
REQ-015 SHALL have ports dec_instr, dec_pc, dec_npc  out  32 each  head instruction, its PC, and PC+4.
REQ-016 SHALL have port stall_cnt  out  CNT_W  count of cycles with imemREN=1 and ihit=0.

Function
REQ-017 SHALL implement FSM states FETCH, STALL, HALTED.
REQ-018 SHALL drive imemREN=1 only in FETCH with count<DEPTH; icache_addr=imemaddr always.
REQ-019 SHALL push {imemload, imemaddr, imemaddr+4 mod 2^32} when imemREN & ihit & ~flush & ~halt.
REQ-020 SHALL pop when dec_valid & dec_ready; push and pop in one cycle leave count unchanged.
REQ-021 SHALL drive pc_en = push | flush; no PC advance otherwise.
REQ-022 SHALL transition FETCH->STALL when count becomes DEPTH without a simultaneous pop.
REQ-023 SHALL transition STALL->FETCH on the cycle after any pop; imemREN remains 0 in STALL.
REQ-024 SHALL transition FETCH or STALL->HALTED on halt=1; HALTED exits only through RST.
REQ-025 SHALL, in HALTED, drive imemREN=0 and pc_en=0, and keep draining buffered entries to decode.
REQ-026 SHALL, on flush=1, clear all entries (count=0, pointers=0) at the next edge; a same-cycle pop still completes; a same-cycle ihit word is discarded.
REQ-027 SHALL, on flush in STALL, return to FETCH; on flush in HALTED, only clear entries.
REQ-028 SHALL give flush priority over halt when both are asserted: entries clear, state goes to HALTED.
REQ-029 SHALL present dec_valid = (count>0); dec_* hold stable while dec_valid & ~dec_ready.
REQ-030 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-031 SHALL never push when count=DEPTH.
REQ-032 SHALL never assert dec_valid when count=0; pop with count=0 is ignored.
REQ-033 SHALL increment stall_cnt when imemREN & ~ihit, saturating at 2^CNT_W-1.
REQ-034 SHALL have latency from ihit to dec_valid of exactly 1 cycle.

Reset
REQ-035 SHALL, with RST=1 at an edge, set state=FETCH, count=0, pointers=0, and stall_cnt=0.
REQ-036 SHALL hold dec_valid=0, imemREN=0, and pc_en=0 throughout any cycle in which RST=1; imemREN=1 is first seen the cycle after RST falls.
REQ-037 SHALL, on reset mid-operation (any state, any count), discard buffered entries with no dec_valid pulse afterward.

Verification
REQ-038 SHALL cover: reset, imemaddr=0, ihit=1 every cycle, dec_ready=1 -> dec_pc 0,4,8 on consecutive cycles starting 1 cycle after first hit; pc_en=1 each hit cycle.
REQ-039 SHALL cover: dec_ready=0, ihit=1 -> two pushes, state STALL, imemREN=0, pc_en=0; dec_ready=1 for one cycle -> FETCH, next push follows.
REQ-040 SHALL cover: ihit=0 for 5 cycles with imemREN=1 -> stall_cnt=5, no push, pc_en=0.
REQ-041 SHALL cover: 2 entries buffered, flush=1 with ihit=1 -> count=0 next cycle, dec_valid=0, pc_en=1 that cycle, hit word dropped.
REQ-042 SHALL cover: halt=1 with 1 entry buffered -> HALTED, imemREN=0 thereafter, entry drains on dec_ready, remains HALTED until RST.
REQ-043 SHALL cover: stall_cnt forced near max (CNT_W=4, 15 miss cycles, then 3 more) -> stall_cnt holds 15.

Source files
------------

// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_if
// Description : Bundle of the PC, instruction-cache and decode handshake
//               signals seen by the fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_buffer_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      imemaddr;
  logic             pc_en;
  logic             imemREN;
  logic [31:0]      icache_addr;
  logic             ihit;
  logic [31:0]      imemload;
  logic             flush;
  logic             halt;
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_instr;
  logic [31:0]      dec_pc;
  logic [31:0]      dec_npc;
  logic [CNT_W-1:0] stall_cnt;

  // Fetch-buffer side
  modport master (
    input  imemaddr, ihit, imemload, flush, halt, dec_ready,
    output pc_en, imemREN, icache_addr, dec_valid, dec_instr, dec_pc,
           dec_npc, stall_cnt
  );

  // Environment side (PC, cache, decode)
  modport slave (
    output imemaddr, ihit, imemload, flush, halt, dec_ready,
    input  pc_en, imemREN, icache_addr, dec_valid, dec_instr, dec_pc,
           dec_npc, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Instruction fetch buffer between the program counter / icache
//               and decode. Small circular queue of {instr, pc}, with
//               FETCH/STALL/HALTED control and a saturating miss counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  fetch_buffer_if.master   bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int               PTR_W       = $clog2(DEPTH);
  localparam int               CNTB        = $clog2(DEPTH + 1);
  localparam logic [CNTB-1:0]  c_depth     = CNTB'(DEPTH);
  localparam logic [CNTB-1:0]  c_one       = CNTB'(1);
  localparam logic [CNT_W-1:0] c_stall_max = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNTB-1:0]   r_count;
  logic [31:0]       r_instr [DEPTH];
  logic [31:0]       r_pc    [DEPTH];
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_imemren;
  logic              w_dec_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_pc_en;

  // Handshake decode and next-state selection; RST masks every request.
  always_comb begin
    w_state_nxt = r_state;
    w_dec_valid = ~RST && (r_count != '0);
    w_imemren   = ~RST && (r_state == FETCH) && (r_count < c_depth);
    w_push      = w_imemren && bus.ihit && ~bus.flush && ~bus.halt;
    w_pop       = w_dec_valid && bus.dec_ready;
    // A redirect still moves the PC, except once halted.
    w_pc_en     = ~RST && (w_push || (bus.flush && (r_state != HALTED)));
    case (r_state)
      FETCH: begin
        if (bus.halt)
          w_state_nxt = HALTED;
        else if (w_push && ~w_pop && (r_count == c_depth - c_one))
          w_state_nxt = STALL;
      end
      STALL: begin
        if (bus.halt)
          w_state_nxt = HALTED;
        else if (bus.flush || w_pop)
          w_state_nxt = FETCH;
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = FETCH;
    endcase
  end

  // Control state register.
  always_ff @(posedge CLK) begin
    if (RST)
      r_state <= FETCH;
    else
      r_state <= w_state_nxt;
  end

  // Queue pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && ~w_pop)
        r_count <= r_count + c_one;
      else if (w_pop && ~w_push)
        r_count <= r_count - c_one;
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= bus.imemload;
      r_pc[r_wr_ptr]    <= bus.imemaddr;
    end
  end

  // Saturating count of cycles spent waiting on the icache.
  always_ff @(posedge CLK) begin
    if (RST)
      r_stall_cnt <= '0;
    else if (w_imemren && ~bus.ihit && (r_stall_cnt != c_stall_max))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.imemREN     = w_imemren;
  assign bus.icache_addr = bus.imemaddr;
  assign bus.pc_en       = w_pc_en;
  assign bus.dec_valid   = w_dec_valid;
  assign bus.dec_instr   = r_instr[r_rd_ptr];
  assign bus.dec_pc      = r_pc[r_rd_ptr];
  // PC+4 wraps naturally in 32 bits.
  assign bus.dec_npc     = r_pc[r_rd_ptr] + 32'd4;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Directed self-checking bench for fetch_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_buffer_if #(.CNT_W(16)) bus ();
  fetch_buffer_if #(.CNT_W(4))  sat ();

  fetch_buffer #(.DEPTH(2), .CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  fetch_buffer #(.DEPTH(2), .CNT_W(4)) dut_sat (
    .CLK (CLK),
    .RST (RST),
    .bus (sat)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.flush = 1'b0; bus.halt = 1'b0; bus.ihit = 1'b0; bus.dec_ready = 1'b0;
    bus.imemaddr = 32'h0; bus.imemload = 32'h0;
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.ihit = 1'b1; bus.dec_ready = 1'b1; bus.imemaddr = 32'h40;
    tick();
    tick();
    checks++; if (bus.imemREN !== 1'b0) begin errors++; $display("FAIL rst_imemren got %0h exp 0", bus.imemREN); end
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid got %0h exp 0", bus.dec_valid); end
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en got %0h exp 0", bus.pc_en); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0h exp 0", bus.stall_cnt); end
    checks++; if (bus.icache_addr !== 32'h40) begin errors++; $display("FAIL rst_icache_addr got %0h exp 40", bus.icache_addr); end
    RST = 1'b0; bus.ihit = 1'b0;
    #1;
    checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL rst_release_imemren got %0h exp 1", bus.imemREN); end
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rst_release_dec_valid got %0h exp 0", bus.dec_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.imemaddr = 32'h0; bus.ihit = 1'b1; bus.dec_ready = 1'b1; bus.imemload = 32'h1000;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL stream_pc_en[%0d] got %0h exp 1", i, bus.pc_en); end
      if (i == 0) begin
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got %0h exp 0", bus.dec_valid); end
      end else begin
        checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h exp 1", i, bus.dec_valid); end
        checks++; if (bus.dec_pc !== 32'((i - 1) * 4)) begin errors++; $display("FAIL stream_pc[%0d] got %0h exp %0h", i, bus.dec_pc, (i - 1) * 4); end
        checks++; if (bus.dec_npc !== 32'(i * 4)) begin errors++; $display("FAIL stream_npc[%0d] got %0h exp %0h", i, bus.dec_npc, i * 4); end
        checks++; if (bus.dec_instr !== 32'(32'h1000 + (i - 1) * 4)) begin errors++; $display("FAIL stream_instr[%0d] got %0h exp %0h", i, bus.dec_instr, 32'h1000 + (i - 1) * 4); end
      end
      tick();
      bus.imemaddr = bus.imemaddr + 32'd4;
      bus.imemload = 32'h1000 + bus.imemaddr;
      #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.imemaddr = 32'h0; bus.ihit = 1'b1; bus.dec_ready = 1'b0; bus.imemload = 32'hA0;
    #1;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL bp_pc_en0 got %0h exp 1", bus.pc_en); end
    tick();
    bus.imemaddr = 32'h4; bus.imemload = 32'hA4;
    #1;
    checks++; if (bus.dec_pc !== 32'h0) begin errors++; $display("FAIL bp_pc1 got %0h exp 0", bus.dec_pc); end
    checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL bp_imemren1 got %0h exp 1", bus.imemREN); end
    tick();
    bus.imemaddr = 32'h8; bus.imemload = 32'hA8;
    #1;
    checks++; if (bus.imemREN !== 1'b0) begin errors++; $display("FAIL bp_stall_imemren got %0h exp 0", bus.imemREN); end
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL bp_stall_pc_en got %0h exp 0", bus.pc_en); end
    checks++; if (bus.dec_pc !== 32'h0) begin errors++; $display("FAIL bp_hold_pc got %0h exp 0", bus.dec_pc); end
    checks++; if (bus.dec_instr !== 32'hA0) begin errors++; $display("FAIL bp_hold_instr got %0h exp a0", bus.dec_instr); end
    bus.dec_ready = 1'b1;
    tick();
    bus.dec_ready = 1'b0;
    #1;
    checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL bp_resume_imemren got %0h exp 1", bus.imemREN); end
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL bp_resume_pc_en got %0h exp 1", bus.pc_en); end
    checks++; if (bus.dec_pc !== 32'h4) begin errors++; $display("FAIL bp_resume_pc got %0h exp 4", bus.dec_pc); end
    tick();
    checks++; if (bus.imemREN !== 1'b0) begin errors++; $display("FAIL bp_restall_imemren got %0h exp 0", bus.imemREN); end
    checks++; if (bus.dec_pc !== 32'h4) begin errors++; $display("FAIL bp_restall_pc got %0h exp 4", bus.dec_pc); end
  endtask

  task automatic test_miss();
    do_reset();
    bus.imemaddr = 32'h0; bus.ihit = 1'b0; bus.dec_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL miss_imemren[%0d] got %0h exp 1", i, bus.imemREN); end
      checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL miss_pc_en[%0d] got %0h exp 0", i, bus.pc_en); end
      tick();
    end
    checks++; if (bus.stall_cnt !== 16'd5) begin errors++; $display("FAIL miss_stall_cnt got %0d exp 5", bus.stall_cnt); end
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL miss_dec_valid got %0h exp 0", bus.dec_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.imemaddr = 32'h0; bus.ihit = 1'b1; bus.dec_ready = 1'b0; bus.imemload = 32'hA0;
    tick();
    bus.imemaddr = 32'h4; bus.imemload = 32'hA4;
    tick();
    bus.imemaddr = 32'h8; bus.imemload = 32'hA8; bus.flush = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL flush_pc_en got %0h exp 1", bus.pc_en); end
    checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %0h exp 1", bus.dec_valid); end
    tick();
    bus.flush = 1'b0; bus.ihit = 1'b0; bus.imemaddr = 32'h100;
    #1;
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared got %0h exp 0", bus.dec_valid); end
    checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL flush_to_fetch got %0h exp 1", bus.imemREN); end
    bus.flush = 1'b1; bus.ihit = 1'b1; bus.imemload = 32'hBB;
    #1;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL flush_hit_pc_en got %0h exp 1", bus.pc_en); end
    tick();
    bus.flush = 1'b0; bus.ihit = 1'b0; bus.imemaddr = 32'h200;
    #1;
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL flush_word_dropped got %0h exp 0", bus.dec_valid); end
    bus.ihit = 1'b1; bus.imemload = 32'hCC;
    tick();
    bus.ihit = 1'b0;
    #1;
    checks++; if (bus.dec_pc !== 32'h200) begin errors++; $display("FAIL flush_redirect_pc got %0h exp 200", bus.dec_pc); end
    checks++; if (bus.dec_instr !== 32'hCC) begin errors++; $display("FAIL flush_redirect_instr got %0h exp cc", bus.dec_instr); end
    checks++; if (bus.dec_npc !== 32'h204) begin errors++; $display("FAIL flush_redirect_npc got %0h exp 204", bus.dec_npc); end
  endtask

  task automatic test_halt();
    do_reset();
    bus.imemaddr = 32'h0; bus.ihit = 1'b1; bus.dec_ready = 1'b0; bus.imemload = 32'h11;
    tick();
    bus.imemaddr = 32'h4; bus.halt = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL halt_pc_en got %0h exp 0", bus.pc_en); end
    tick();
    bus.halt = 1'b0;
    #1;
    checks++; if (bus.imemREN !== 1'b0) begin errors++; $display("FAIL halted_imemren got %0h exp 0", bus.imemREN); end
    checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL halted_valid got %0h exp 1", bus.dec_valid); end
    checks++; if (bus.dec_pc !== 32'h0) begin errors++; $display("FAIL halted_pc got %0h exp 0", bus.dec_pc); end
    bus.dec_ready = 1'b1;
    tick();
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL halted_drained got %0h exp 0", bus.dec_valid); end
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL halted_flush_pc_en got %0h exp 0", bus.pc_en); end
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.imemREN !== 1'b0) begin errors++; $display("FAIL halted_stays[%0d] got %0h exp 0", i, bus.imemREN); end
    end
    // Only reset leaves HALTED.
    do_reset();
    bus.ihit = 1'b1; bus.dec_ready = 1'b0; bus.imemaddr = 32'h0;
    #1;
    checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL halt_exit_reset got %0h exp 1", bus.imemREN); end
    tick();
    // flush and halt together: flush clears, state still goes to HALTED
    bus.imemaddr = 32'h4; bus.flush = 1'b1; bus.halt = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL fh_pc_en got %0h exp 1", bus.pc_en); end
    tick();
    bus.flush = 1'b0; bus.halt = 1'b0;
    #1;
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL fh_cleared got %0h exp 0", bus.dec_valid); end
    checks++; if (bus.imemREN !== 1'b0) begin errors++; $display("FAIL fh_halted got %0h exp 0", bus.imemREN); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.imemaddr = 32'h0; bus.ihit = 1'b1; bus.dec_ready = 1'b0;
    tick();
    bus.imemaddr = 32'h4;
    tick();
    bus.ihit = 1'b0; RST = 1'b1;
    #1;
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL midrst_during got %0h exp 0", bus.dec_valid); end
    tick();
    RST = 1'b0;
    #1;
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got %0h exp 0", bus.dec_valid); end
    tick();
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL midrst_later got %0h exp 0", bus.dec_valid); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 14; i++) tick();
    checks++; if (sat.stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d exp 14", sat.stall_cnt); end
    tick();
    checks++; if (sat.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d exp 15", sat.stall_cnt); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (sat.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", sat.stall_cnt); end
    checks++; if (sat.imemREN !== 1'b1) begin errors++; $display("FAIL sat_imemren got %0h exp 1", sat.imemREN); end
  endtask

  initial begin
    bus.imemaddr = 32'h0; bus.ihit = 1'b0; bus.imemload = 32'h0;
    bus.flush = 1'b0; bus.halt = 1'b0; bus.dec_ready = 1'b0;
    sat.imemaddr = 32'h0; sat.ihit = 1'b0; sat.imemload = 32'h0;
    sat.flush = 1'b0; sat.halt = 1'b0; sat.dec_ready = 1'b0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_miss();
    test_flush();
    test_halt();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
